traffic_lights_cmd_sender: RTL and testbench
============================================

TRAFFIC_LIGHTS_CMD_SENDER -- requirements
Module: traffic_lights_cmd_sender

Interface
REQ-001 The module SHALL have parameter CMD_GAP_TICKS, default 0: idle cycles (cmd_valid_o low) inserted between consecutive commands of one sequence.
REQ-002 The module SHALL have parameter MAX_TIME_MS, default 16'd65535: upper clamp for programmed times.
REQ-003 clk_2k_i  input  1  single clock; all logic on its rising edge.
REQ-004 srst_i  input  1  reset, synchronous, active-high.
REQ-005 req_valid_i  input  1  upstream request valid.
REQ-006 req_ready_o  output  1  sender can accept a request.
REQ-007 req_kind_i  input  2  0 = PROGRAM, 1 = MANUAL, 2 = ON, 3 = reserved.
REQ-008 red_ms_i, yellow_ms_i, green_ms_i  input  16 each  phase times in ms; sampled only for PROGRAM.
REQ-009 cmd_type_o  output  command_e (definitions_pkg)  command to traffic_lights cmd_type_i.
REQ-010 cmd_valid_o  output  1  command valid, one cycle per command.
REQ-011 cmd_data_o  output  16  command payload.
REQ-012 done_o  output  1  one-cycle pulse after the last command of a sequence.
REQ-013 clamp_o  output  1  one-cycle pulse on acceptance of a PROGRAM with any time clamped.

Function
REQ-014 req_ready_o SHALL be 1 only in state IDLE; a request is accepted on a cycle with req_valid_i && req_ready_o.
REQ-015 At acceptance, req_kind_i and all three times SHALL be registered; later input changes SHALL NOT affect the sequence in flight.
REQ-016 Clamping at acceptance: a time of 0 SHALL become 1; a time > MAX_TIME_MS SHALL become MAX_TIME_MS; clamp_o SHALL pulse on the next cycle if any of the three was modified.
REQ-017 Sequences: PROGRAM = SET_MANUAL, SET_RED(red), SET_YELLOW(yellow), SET_GREEN(green), SET_ON; MANUAL = SET_MANUAL; ON = SET_ON.
REQ-018 req_kind_i = 3 SHALL be accepted and dropped: no command, no done_o, no clamp_o.
REQ-019 FSM states: IDLE, S_MANUAL, S_RED, S_YELLOW, S_GREEN, S_ON, GAP, DONE. Transitions: IDLE to the first command state on acceptance; each command state lasts exactly one cycle; it goes to GAP if CMD_GAP_TICKS > 0 and more commands remain, else to the next command state, or to DONE after the last command; GAP lasts CMD_GAP_TICKS cycles; DONE lasts one cycle and returns to IDLE.
REQ-020 Latency: the first command SHALL have cmd_valid_o = 1 in the cycle after acceptance.
REQ-021 With CMD_GAP_TICKS = 0, a PROGRAM sequence SHALL occupy 5 consecutive valid cycles, then DONE for 1 cycle, giving 7 cycles from acceptance until req_ready_o is 1 again.
REQ-022 cmd_type_o, cmd_valid_o and cmd_data_o SHALL be driven from registers (no combinational path from inputs).
REQ-023 cmd_data_o SHALL carry the clamped time for SET_RED, SET_YELLOW and SET_GREEN, and 16'd0 for all other cycles; it SHALL never be X.
REQ-024 While cmd_valid_o = 0, cmd_type_o SHALL hold SET_ON (defined value, ignored by the receiver).
REQ-025 done_o SHALL pulse exactly once per accepted sequence, in the DONE cycle, with cmd_valid_o = 0.
REQ-026 There is no backpressure from traffic_lights; commands SHALL NOT be stalled or repeated.

Reset
REQ-027 On srst_i = 1 at a clock edge, the FSM SHALL go to IDLE, cmd_valid_o = 0, cmd_data_o = 0, cmd_type_o = SET_ON, done_o = 0, clamp_o = 0, and the gap counter = 0.
REQ-028 Reset mid-sequence SHALL abort it: no further commands and no done_o; req_ready_o SHALL be 1 in the first cycle after srst_i deasserts.
REQ-029 Requests presented while srst_i = 1 SHALL NOT be accepted.

Verification
REQ-030 PROGRAM red = 10, yellow = 20, green = 30, gap 0 -> valid cycles 1..5 after accept: MANUAL/0, RED/10, YELLOW/20, GREEN/30, ON/0; done_o at cycle 6; ready at cycle 7.
REQ-031 PROGRAM red = 0, green = 70000 is not expressible in 16 bits, so use MAX_TIME_MS = 100 with green = 500 -> RED/1, GREEN/100, clamp_o pulses once.
REQ-032 CMD_GAP_TICKS = 2, MANUAL then PROGRAM -> 1 valid cycle then done; PROGRAM commands spaced by exactly 2 low cycles; total 5 + 8 + 1 cycles.
REQ-033 srst_i asserted during S_YELLOW -> no SET_GREEN, SET_ON or done_o; a new ON request is accepted the cycle after reset and gives ON/0 one cycle later.
REQ-034 req_valid_i held high with kind 3 followed by ON -> kind 3 produces no outputs; ON is accepted once ready returns.
REQ-035 End-to-end: the sender drives the traffic_lights instance with random times 1..100 -> the lights follow red, red+yellow, green, blink, yellow with the programmed durations.

Source files
------------

// File: rtl/traffic_lights_cmd_sender.sv
// ---------------------------------------------------------------------------
// traffic_lights_cmd_sender
//
// Turns one upstream request into a short, fixed sequence of commands for a
// traffic_lights controller. The commands are optionally spaced by idle gap
// cycles. Requests are accepted only while idle. Phase times are clamped
// and captured at acceptance, so later input changes cannot disturb a
// sequence that is already running.
//
// Sequences:
//   PROGRAM : SET_MANUAL, SET_RED(red), SET_YELLOW(yellow), SET_GREEN(green), SET_ON
//   MANUAL  : SET_MANUAL
//   ON      : SET_ON
//   kind 3  : accepted and silently dropped
//
// Parameters:
//   CMD_GAP_TICKS  idle cycles between consecutive commands of one sequence
//   MAX_TIME_MS    upper clamp for programmed times (0 is raised to 1)
//
// Ports:
//   clk_2k_i      in   single clock, rising edge
//   srst_i        in   synchronous active-high reset
//   req_valid_i   in   request valid
//   req_ready_o   out  high only while idle
//   req_kind_i    in   0 PROGRAM, 1 MANUAL, 2 ON, 3 reserved
//   red_ms_i      in   red time in ms (PROGRAM only)
//   yellow_ms_i   in   yellow time in ms (PROGRAM only)
//   green_ms_i    in   green time in ms (PROGRAM only)
//   cmd_type_o    out  command; holds SET_ON while cmd_valid_o is low
//   cmd_valid_o   out  one cycle per command, no backpressure
//   cmd_data_o    out  clamped time for SET_RED/YELLOW/GREEN, else 0
//   done_o        out  one-cycle pulse after the last command
//   clamp_o       out  one-cycle pulse when an accepted PROGRAM was clamped
// ---------------------------------------------------------------------------

package definitions_pkg;
    typedef enum logic [2:0] {
        SET_ON     = 3'd0,
        SET_OFF    = 3'd1,
        SET_MANUAL = 3'd2,
        SET_GREEN  = 3'd3,
        SET_RED    = 3'd4,
        SET_YELLOW = 3'd5
    } command_e;
endpackage

module traffic_lights_cmd_sender
    import definitions_pkg::*;
#(
    parameter int          CMD_GAP_TICKS = 0,
    parameter logic [15:0] MAX_TIME_MS   = 16'd65535
) (
    input  logic        clk_2k_i,
    input  logic        srst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_kind_i,
    input  logic [15:0] red_ms_i,
    input  logic [15:0] yellow_ms_i,
    input  logic [15:0] green_ms_i,
    output command_e    cmd_type_o,
    output logic        cmd_valid_o,
    output logic [15:0] cmd_data_o,
    output logic        done_o,
    output logic        clamp_o
);

    localparam logic [1:0] KIND_PROGRAM = 2'd0;
    localparam logic [1:0] KIND_MANUAL  = 2'd1;
    localparam logic [1:0] KIND_ON      = 2'd2;

    typedef enum logic [2:0] {
        IDLE, S_MANUAL, S_RED, S_YELLOW, S_GREEN, S_ON, GAP, DONE
    } state_e;

    state_e      r_state;
    state_e      r_resume;      // command state to enter when the gap expires
    logic [15:0] r_gap_cnt;
    logic [1:0]  r_kind;
    logic [15:0] r_red;
    logic [15:0] r_yellow;
    logic [15:0] r_green;
    logic        r_cmd_valid;
    command_e    r_cmd_type;
    logic [15:0] r_cmd_data;
    logic        r_done;
    logic        r_clamp;

    state_e      w_next_state;
    state_e      w_follow;      // command (or DONE) after the current command
    logic        w_gap_load;
    logic        w_accept;
    logic [15:0] w_red_c;
    logic [15:0] w_yellow_c;
    logic [15:0] w_green_c;
    logic        w_clamp_any;
    logic        w_cmd_valid;
    command_e    w_cmd_type;
    logic [15:0] w_cmd_data;

    function automatic logic [15:0] clamp_time(input logic [15:0] t);
        if (t == 16'd0)
            return 16'd1;
        else if (t > MAX_TIME_MS)
            return MAX_TIME_MS;
        else
            return t;
    endfunction

    assign req_ready_o = (r_state == IDLE);
    assign w_accept    = req_valid_i && req_ready_o;

    assign w_red_c     = clamp_time(red_ms_i);
    assign w_yellow_c  = clamp_time(yellow_ms_i);
    assign w_green_c   = clamp_time(green_ms_i);
    assign w_clamp_any = (w_red_c != red_ms_i) || (w_yellow_c != yellow_ms_i) ||
                         (w_green_c != green_ms_i);

    // Successor of the command currently on the wire; only PROGRAM chains.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_follow = DONE;
        case (r_state)
            S_MANUAL: w_follow = (r_kind == KIND_PROGRAM) ? S_RED : DONE;
            S_RED:    w_follow = S_YELLOW;
            S_YELLOW: w_follow = S_GREEN;
            S_GREEN:  w_follow = S_ON;
            default:  w_follow = DONE;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_gap_load   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    case (req_kind_i)
                        KIND_PROGRAM, KIND_MANUAL: w_next_state = S_MANUAL;
                        KIND_ON:                   w_next_state = S_ON;
                        default:                   w_next_state = IDLE;  // reserved: drop
                    endcase
                end
            end
            S_MANUAL, S_RED, S_YELLOW, S_GREEN, S_ON: begin
                if ((w_follow != DONE) && (CMD_GAP_TICKS > 0)) begin
                    w_next_state = GAP;
                    w_gap_load   = 1'b1;
                end else begin
                    w_next_state = w_follow;
                end
            end
            GAP:     if (r_gap_cnt == 16'd0) w_next_state = r_resume;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they line up with the state register and have no input-to-output path.
    always_comb begin
        w_cmd_valid = 1'b0;
        w_cmd_type  = SET_ON;
        w_cmd_data  = 16'd0;
        case (w_next_state)
            S_MANUAL: begin w_cmd_valid = 1'b1; w_cmd_type = SET_MANUAL; end
            S_RED:    begin w_cmd_valid = 1'b1; w_cmd_type = SET_RED;    w_cmd_data = r_red;    end
            S_YELLOW: begin w_cmd_valid = 1'b1; w_cmd_type = SET_YELLOW; w_cmd_data = r_yellow; end
            S_GREEN:  begin w_cmd_valid = 1'b1; w_cmd_type = SET_GREEN;  w_cmd_data = r_green;  end
            S_ON:     begin w_cmd_valid = 1'b1; w_cmd_type = SET_ON;     end
            default:  ;
        endcase
    end

    always_ff @(posedge clk_2k_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (srst_i) begin
            r_state     <= IDLE;
            r_resume    <= IDLE;
            r_gap_cnt   <= 16'd0;
            r_kind      <= KIND_PROGRAM;
            r_red       <= 16'd0;
            r_yellow    <= 16'd0;
            r_green     <= 16'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= SET_ON;
            r_cmd_data  <= 16'd0;
            r_done      <= 1'b0;
            r_clamp     <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_cmd_valid <= w_cmd_valid;
            r_cmd_type  <= w_cmd_type;
            r_cmd_data  <= w_cmd_data;
            r_done      <= (w_next_state == DONE);
            r_clamp     <= w_accept && (req_kind_i == KIND_PROGRAM) && w_clamp_any;

            if (w_accept) begin
                r_kind   <= req_kind_i;
                r_red    <= w_red_c;
                r_yellow <= w_yellow_c;
                r_green  <= w_green_c;
            end

            // Loaded with TICKS-1 so GAP spans exactly CMD_GAP_TICKS cycles.
            if (w_gap_load) begin
                r_gap_cnt <= 16'(CMD_GAP_TICKS - 1);
                r_resume  <= w_follow;
            end else if ((r_state == GAP) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end
        end
    end

    assign cmd_valid_o = r_cmd_valid;
    assign cmd_type_o  = r_cmd_type;
    assign cmd_data_o  = r_cmd_data;
    assign done_o      = r_done;
    assign clamp_o     = r_clamp;

endmodule

// File: tb/tb_traffic_lights_cmd_sender.sv
// ---------------------------------------------------------------------------
// tb_traffic_lights_cmd_sender
//
// Two instances share one clock:
//   dut 0 : CMD_GAP_TICKS = 0, MAX_TIME_MS = 100 (back-to-back commands, clamp)
//   dut 1 : CMD_GAP_TICKS = 2, default MAX_TIME_MS (gap spacing)
// Every expected output (clamp pulse, command, done pulse) is pushed with its
// absolute cycle number when a request is driven. A negedge monitor pops and
// compares each output the DUT actually produces.
// ---------------------------------------------------------------------------

module tb_traffic_lights_cmd_sender;
    import definitions_pkg::*;

    localparam logic [1:0] K_PROGRAM = 2'd0;
    localparam logic [1:0] K_MANUAL  = 2'd1;
    localparam logic [1:0] K_ON      = 2'd2;
    localparam logic [1:0] K_RSVD    = 2'd3;

    localparam int EV_CMD   = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_CLAMP = 2;

    typedef struct {
        int          cyc;
        int          ev;
        logic [2:0]  typ;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        srst        [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [1:0]  req_kind    [2];
    logic [15:0] red_ms      [2];
    logic [15:0] yellow_ms   [2];
    logic [15:0] green_ms    [2];
    command_e    cmd_type    [2];
    logic        cmd_valid   [2];
    logic [15:0] cmd_data    [2];
    logic        done        [2];
    logic        clamp       [2];

    int   cyc     = 0;
    int   n_check = 0;
    int   n_fail  = 0;
    logic mon_en  = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    traffic_lights_cmd_sender #(.CMD_GAP_TICKS(0), .MAX_TIME_MS(16'd100)) u_dut0 (
        .clk_2k_i(clk), .srst_i(srst[0]), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
        .req_kind_i(req_kind[0]), .red_ms_i(red_ms[0]), .yellow_ms_i(yellow_ms[0]),
        .green_ms_i(green_ms[0]), .cmd_type_o(cmd_type[0]), .cmd_valid_o(cmd_valid[0]),
        .cmd_data_o(cmd_data[0]), .done_o(done[0]), .clamp_o(clamp[0])
    );

    traffic_lights_cmd_sender #(.CMD_GAP_TICKS(2)) u_dut1 (
        .clk_2k_i(clk), .srst_i(srst[1]), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
        .req_kind_i(req_kind[1]), .red_ms_i(red_ms[1]), .yellow_ms_i(yellow_ms[1]),
        .green_ms_i(green_ms[1]), .cmd_type_o(cmd_type[1]), .cmd_valid_o(cmd_valid[1]),
        .cmd_data_o(cmd_data[1]), .done_o(done[1]), .clamp_o(clamp[1])
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] clamp_m(input logic [15:0] t, input logic [15:0] mx);
        if (t == 16'd0) return 16'd1;
        if (t > mx)     return mx;
        return t;
    endfunction

    task automatic push_ev(input int id, input int c, input int ev, input logic [2:0] typ,
                           input logic [15:0] data);
        exp_t e;
        e.cyc = c; e.ev = ev; e.typ = typ; e.data = data;
        if (id == 0) q0.push_back(e);
        else         q1.push_back(e);
    endtask

    function automatic exp_t pop_ev(input int id);
        exp_t e;
        e.cyc = -1; e.ev = -1; e.typ = 3'd7; e.data = 16'hDEAD;
        if (id == 0) begin
            if (q0.size() > 0) e = q0.pop_front();
        end else begin
            if (q1.size() > 0) e = q1.pop_front();
        end
        return e;
    endfunction

    // Expected outputs of one accepted request; keep limits how many commands
    // are expected (a reset cuts the sequence short and suppresses done).
    task automatic push_seq(input int id, input logic [1:0] kind, input logic [15:0] r,
                            input logic [15:0] y, input logic [15:0] g, input int acc,
                            input int keep);
        int          step;
        logic [15:0] mx;
        logic [15:0] rc, yc, gc;
        logic [2:0]  ts [5];
        logic [15:0] ds [5];
        step = (id == 0) ? 1 : 3;
        mx   = (id == 0) ? 16'd100 : 16'd65535;
        case (kind)
            K_PROGRAM: begin
                rc = clamp_m(r, mx); yc = clamp_m(y, mx); gc = clamp_m(g, mx);
                if (rc != r || yc != y || gc != g) push_ev(id, acc, EV_CLAMP, 3'd0, 16'd0);
                ts[0] = SET_MANUAL; ts[1] = SET_RED; ts[2] = SET_YELLOW;
                ts[3] = SET_GREEN;  ts[4] = SET_ON;
                ds[0] = 16'd0; ds[1] = rc; ds[2] = yc; ds[3] = gc; ds[4] = 16'd0;
                for (int i = 0; i < 5 && i < keep; i++)
                    push_ev(id, acc + i * step, EV_CMD, ts[i], ds[i]);
                if (keep >= 5) push_ev(id, acc + 4 * step + 1, EV_DONE, 3'd0, 16'd0);
            end
            K_MANUAL: begin
                push_ev(id, acc, EV_CMD, SET_MANUAL, 16'd0);
                push_ev(id, acc + 1, EV_DONE, 3'd0, 16'd0);
            end
            K_ON: begin
                push_ev(id, acc, EV_CMD, SET_ON, 16'd0);
                push_ev(id, acc + 1, EV_DONE, 3'd0, 16'd0);
            end
            default: ;
        endcase
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after a posedge; returns #1 after the accepting edge.
    task automatic send(input int id, input logic [1:0] kind, input logic [15:0] r,
                        input logic [15:0] y, input logic [15:0] g, input int keep,
                        output int acc);
        int waited = 0;
        while (!req_ready[id] && waited < 50) begin
            wait_cycles(1);
            waited++;
        end
        check($sformatf("dut%0d_ready_before_send", id), req_ready[id], 1'b1);
        req_valid[id] = 1'b1; req_kind[id] = kind;
        red_ms[id] = r; yellow_ms[id] = y; green_ms[id] = g;
        acc = cyc + 1;
        push_seq(id, kind, r, y, g, acc, keep);
        wait_cycles(1);
        // Scramble inputs: the sequence in flight must use the captured values.
        req_valid[id] = 1'b0; req_kind[id] = K_PROGRAM;
        red_ms[id] = 16'hFFFF; yellow_ms[id] = 16'h0000; green_ms[id] = 16'h7777;
    endtask

    task automatic observe(input int id, input int ev, input logic [2:0] typ,
                           input logic [15:0] data);
        exp_t e;
        e = pop_ev(id);
        check($sformatf("dut%0d_ev_cycle", id), 64'(cyc), 64'(e.cyc));
        check($sformatf("dut%0d_ev_kind", id), 64'(ev), 64'(e.ev));
        check($sformatf("dut%0d_cmd_type", id), typ, e.typ);
        check($sformatf("dut%0d_cmd_data", id), data, e.data);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int id = 0; id < 2; id++) begin
                if (clamp[id])     observe(id, EV_CLAMP, 3'd0, 16'd0);
                if (cmd_valid[id]) observe(id, EV_CMD, cmd_type[id], cmd_data[id]);
                if (done[id]) begin
                    observe(id, EV_DONE, 3'd0, 16'd0);
                    check($sformatf("dut%0d_done_with_valid", id), cmd_valid[id], 1'b0);
                end
                if (!cmd_valid[id]) begin
                    check($sformatf("dut%0d_idle_type", id), cmd_type[id], SET_ON);
                    check($sformatf("dut%0d_idle_data", id), cmd_data[id], 16'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int acc2;
        for (int i = 0; i < 2; i++) begin
            srst[i] = 1'b1; req_valid[i] = 1'b0; req_kind[i] = K_PROGRAM;
            red_ms[i] = 16'd0; yellow_ms[i] = 16'd0; green_ms[i] = 16'd0;
        end
        wait_cycles(2);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_rst_valid", i), cmd_valid[i], 1'b0);
            check($sformatf("dut%0d_rst_type", i),  cmd_type[i], SET_ON);
            check($sformatf("dut%0d_rst_data", i),  cmd_data[i], 16'd0);
            check($sformatf("dut%0d_rst_done", i),  done[i], 1'b0);
            check($sformatf("dut%0d_rst_clamp", i), clamp[i], 1'b0);
            check($sformatf("dut%0d_rst_ready", i), req_ready[i], 1'b1);
            srst[i] = 1'b0;
        end
        mon_en = 1'b1;

        // Nominal PROGRAM: ready low through DONE, back high 7 cycles after accept.
        send(0, K_PROGRAM, 16'd10, 16'd20, 16'd30, 5, acc);
        check("prog_ready_busy", req_ready[0], 1'b0);
        wait_cycles(5);
        check("prog_ready_in_done", req_ready[0], 1'b0);
        wait_cycles(1);
        check("prog_ready_back", req_ready[0], 1'b1);

        // Clamping: 0 -> 1, 500 -> MAX_TIME_MS (100), 100 left untouched.
        send(0, K_PROGRAM, 16'd0, 16'd100, 16'd500, 5, acc);
        // No clamp: boundary values 1 and MAX pass through.
        send(0, K_PROGRAM, 16'd1, 16'd100, 16'd99, 5, acc);
        send(0, K_MANUAL, 16'd5, 16'd5, 16'd5, 5, acc);
        send(0, K_ON, 16'd0, 16'd0, 16'd0, 5, acc);
        for (int i = 0; i < 4; i++)
            send(0, K_PROGRAM, 16'($urandom_range(0, 150)), 16'($urandom_range(0, 150)),
                 16'($urandom_range(0, 150)), 5, acc);

        // Reserved kind is accepted and dropped; ON held behind it is taken next.
        while (!req_ready[0]) wait_cycles(1);
        req_valid[0] = 1'b1; req_kind[0] = K_RSVD;
        wait_cycles(1);
        check("rsvd_ready_stays", req_ready[0], 1'b1);
        req_kind[0] = K_ON;
        push_seq(0, K_ON, 16'd0, 16'd0, 16'd0, cyc + 1, 5);
        wait_cycles(1);
        req_valid[0] = 1'b0;

        // Reset during S_YELLOW aborts; requests during reset are ignored.
        send(0, K_PROGRAM, 16'd10, 16'd20, 16'd30, 3, acc);
        wait_cycles(2);
        srst[0] = 1'b1; req_valid[0] = 1'b1; req_kind[0] = K_ON;
        wait_cycles(2);
        srst[0] = 1'b0;
        check("rst_abort_ready", req_ready[0], 1'b1);
        check("rst_abort_valid", cmd_valid[0], 1'b0);
        check("rst_abort_done", done[0], 1'b0);
        acc2 = cyc + 1;
        check("rst_resume_cycle", 64'(acc2), 64'(acc + 5));
        push_seq(0, K_ON, 16'd0, 16'd0, 16'd0, acc2, 5);
        wait_cycles(1);
        req_valid[0] = 1'b0;

        // Gapped instance: MANUAL, then PROGRAM spanning 5 + 8 + 1 cycles.
        send(1, K_MANUAL, 16'd0, 16'd0, 16'd0, 5, acc);
        send(1, K_PROGRAM, 16'd0, 16'd6, 16'd7, 5, acc);
        wait_cycles(13);
        check("gap_ready_in_done", req_ready[1], 1'b0);
        wait_cycles(1);
        check("gap_ready_back", req_ready[1], 1'b1);

        wait_cycles(20);
        check("dut0_pending", 64'(q0.size()), 64'd0);
        check("dut1_pending", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

endmodule
